bam_seq_mult: RTL and testbench
===============================

Name: bam_seq_mult

Overview:
- Parametrised, sequential successor to the team's 8-bit carry-save array multiplier.
- Uses a single carry-save row cell iteratively: one partial-product row is compressed per cycle into registered sum/carry vectors, then one final carry-propagate add produces the result.
- Optional broken-array approximation drops partial-product bits by row (HBL) and by column (VBL), selectable per operation.
- Sits between operand producers and consumers, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product width is 2*WIDTH.
- HBL_W, $clog2(WIDTH+1), width of the hbl input.
- VBL_W, $clog2(2*WIDTH+1), width of the vbl input.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned; b[k] selects row k.
- approx_en  input  1  1 = apply hbl/vbl; 0 = exact.
- hbl  input  HBL_W  horizontal break level: rows k < hbl are dropped.
- vbl  input  VBL_W  vertical break level: bits in columns < vbl are dropped.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- p  output  2*WIDTH  product.
- busy  output  1  high in ACCUM or RESOLVE.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). Reset forces state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, and clears all S/C/operand/count registers.
- Reset asserted mid-operation aborts the operation. No output is produced for it.
- State machine states: IDLE, ACCUM, RESOLVE, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Acceptance: occurs on a clock edge with in_valid & in_ready.
  - Latches a, b, approx_en, hbl, vbl.
  - Clears S and C (each 2*WIDTH bits).
  - Sets row counter k=0 and moves to ACCUM.
- ACCUM: on each edge, row pp_k = ({WIDTH{b[k]}} & a) << k, with masking applied.
  - Masking: if approx_en, bit (i+k) of row k is zeroed when k < hbl or (i+k) < vbl.
  - Update: S <= S ^ C ^ pp_k; C <= maj(S, C, pp_k) << 1, truncated to 2*WIDTH bits.
  - k increments. After row WIDTH-1 is processed, move to RESOLVE.
  - Dropped rows still consume their cycle, so latency is fixed and data-independent.
- RESOLVE: p <= S + C (mod 2^(2*WIDTH)); out_valid <= 1; move to DONE.
- Latency: out_valid rises after WIDTH+1 edges following the acceptance edge (9 for WIDTH=8).
- DONE: p and out_valid are held stable until out_ready=1.
  - out_ready=1 with in_valid=1 on the same edge: the product is consumed, new operands are accepted, and the state moves to ACCUM (back-to-back, no IDLE bubble). out_valid drops to 0.
  - out_ready=1 with in_valid=0: move to IDLE, out_valid drops to 0.
- in_valid is ignored in ACCUM and RESOLVE; in_ready=0 there.
- Arithmetic rules:
  - approx_en=0: p == a*b exactly.
  - approx_en=1: p == sum over kept bits a[i]&b[k] of 2^(i+k). This is an exact golden model with no further rounding.
- Clamping:
  - hbl >= WIDTH drops all rows, giving p=0.
  - vbl >= 2*WIDTH-1 drops all columns, giving p=0.
  - hbl=0 and vbl=0 with approx_en=1 gives the exact product.
- Changes to a, b, or mode inputs after acceptance have no effect on the operation in flight.
- busy=1 only in ACCUM and RESOLVE.

Test Plan:
- WIDTH=8, exact mode: a=255, b=255 -> p=65025, out_valid exactly 9 edges after acceptance, busy high for 9 cycles. Also a=0, b=200 -> p=0.
- WIDTH=8, approx_en=1, hbl=2, vbl=0, a=b=255 -> p=64260. Then hbl=0, vbl=8, a=b=255 -> p=63232. Then hbl=8 -> p=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> p and out_valid stable, in_ready=0. Then out_ready=1 -> out_valid drops on the next edge.
- Back-to-back: in DONE, out_ready=1 and in_valid=1 with a=3, b=5 on the same edge -> first product consumed and second accepted on that edge; p=15 after 9 more edges.
- Reset mid-op: assert rst_n=0 asynchronously during ACCUM row 4 -> outputs immediately at reset values. Release, then issue a=10, b=12 -> p=120 with normal latency.
- Parameter sweep: WIDTH=4, a=15, b=15 -> p=225 after 5 edges. Randomised 10k operations per mode against the golden model.

Source files
------------

// File: rtl/bam_seq_mult.sv
// rtl/bam_seq_mult.sv - sequential carry-save multiplier with broken-array approximation
// One masked partial-product row per cycle into S/C registers, then one carry-propagate add.
module bam_seq_mult #(
  parameter int WIDTH = 8,
  parameter int HBL_W = $clog2(WIDTH+1),
  parameter int VBL_W = $clog2(2*WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_en,
  input  logic [HBL_W-1:0]   hbl,
  input  logic [VBL_W-1:0]   vbl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  localparam int PW = 2*WIDTH;
  localparam int KW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             approx_q, approx_d;
  logic [HBL_W-1:0] hbl_q, hbl_d;
  logic [VBL_W-1:0] vbl_q, vbl_d;
  logic [PW-1:0]    s_q, s_d, c_q, c_d, p_q, p_d;
  logic [KW-1:0]    k_q, k_d;
  logic [PW-1:0]    pp, maj;
  logic             accept;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ACCUM) || (state_q == RESOLVE);
  assign p         = p_q;

  // Current row, with whole-row (hbl) and low-column (vbl) drops applied.
  always_comb begin
    pp = {{WIDTH{1'b0}}, a_q & {WIDTH{b_q[k_q]}}} << k_q;
    if (approx_q) begin
      if (32'(k_q) < 32'(hbl_q)) pp = '0;
      for (int j = 0; j < PW; j++) begin
        if (j < int'(vbl_q)) pp[j] = 1'b0;
      end
    end
    maj = (s_q & c_q) | (s_q & pp) | (c_q & pp);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    approx_d = approx_q;
    hbl_d    = hbl_q;
    vbl_d    = vbl_q;
    s_d      = s_q;
    c_d      = c_q;
    p_d      = p_q;
    k_d      = k_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_d      = a;
          b_d      = b;
          approx_d = approx_en;
          hbl_d    = hbl;
          vbl_d    = vbl;
          s_d      = '0;
          c_d      = '0;
          k_d      = '0;
          state_d  = ACCUM;
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        s_d = s_q ^ c_q ^ pp;
        c_d = maj << 1;
        if (k_q == KW'(WIDTH-1)) state_d = RESOLVE;
        else                     k_d     = k_q + KW'(1);
      end
      RESOLVE: begin
        p_d     = s_q + c_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      hbl_q    <= '0;
      vbl_q    <= '0;
      s_q      <= '0;
      c_q      <= '0;
      p_q      <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      approx_q <= approx_d;
      hbl_q    <= hbl_d;
      vbl_q    <= vbl_d;
      s_q      <= s_d;
      c_q      <= c_d;
      p_q      <= p_d;
      k_q      <= k_d;
    end
  end
endmodule

// File: tb/tb_bam_seq_mult.sv
// tb/tb_bam_seq_mult.sv - bench for bam_seq_mult against a transaction-level golden model
module tb_bam_seq_mult;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, approx_en, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [3:0]  hbl;
  logic [4:0]  vbl;
  logic [15:0] p;

  logic        in_valid4, in_ready4, approx_en4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4;
  logic [2:0]  hbl4;
  logic [3:0]  vbl4;
  logic [7:0]  p4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bam_seq_mult #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .approx_en(approx_en), .hbl(hbl), .vbl(vbl), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .busy(busy)
  );

  bam_seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .approx_en(approx_en4), .hbl(hbl4), .vbl(vbl4), .out_valid(out_valid4),
    .out_ready(out_ready4), .p(p4), .busy(busy4)
  );

  function automatic void check(input string nm, input longint unsigned act,
                                input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Sum of every kept a[i]&b[k] bit weight; no carry-save structure involved.
  function automatic logic [15:0] golden(input logic [7:0] ga, input logic [7:0] gb,
                                          input logic ap, input int h, input int v);
    logic [31:0] s;
    s = 0;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 8; i++)
        if (ga[i] && gb[k] && !(ap && (k < h || i + k < v)))
          s += 32'(1) << (i + k);
    return s[15:0];
  endfunction

  // Transaction model: one op in flight, result 9 edges after acceptance, held until taken.
  logic        m_inflight, m_valid, m_in_ready;
  int          m_cnt;
  logic [15:0] m_exp, m_p;

  assign m_in_ready = !m_inflight && (!m_valid || out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight <= 1'b0;
      m_valid    <= 1'b0;
      m_cnt      <= 0;
      m_exp      <= '0;
      m_p        <= '0;
    end else begin
      if (m_valid && out_ready) m_valid <= 1'b0;
      if (m_inflight) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 8) begin
          m_valid    <= 1'b1;
          m_p        <= m_exp;
          m_inflight <= 1'b0;
        end
      end
      if (in_valid && m_in_ready) begin
        m_inflight <= 1'b1;
        m_cnt      <= 0;
        m_exp      <= golden(a, b, approx_en, int'(hbl), int'(vbl));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("out_valid", out_valid, m_valid);
      check("in_ready", in_ready, m_in_ready);
      check("busy", busy, m_inflight);
      if (m_valid) check("p", p, m_p);
    end
  end

  task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic ap,
                          input logic [3:0] h, input logic [4:0] v);
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb; approx_en = ap; hbl = h; vbl = v; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) check("accept timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); approx_en = ~ap;
    hbl = 4'($urandom); vbl = 5'($urandom);
  endtask

  // Called #1 after the acceptance edge.
  task automatic wait_result(input logic [15:0] exp_p, input string nm);
    int n, nb;
    nb = busy ? 1 : 0;
    n  = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1; n++;
      if (busy) nb++;
    end
    check({nm, " latency"}, n, 9);
    check({nm, " busy cycles"}, nb, 9);
    check({nm, " p"}, p, exp_p);
  endtask

  task automatic consume();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid drop", out_valid, 0);
    out_ready = 1'b0;
  endtask

  task automatic stream(input logic ap, input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = 8'($urandom); b = 8'($urandom); approx_en = ap;
      hbl = 4'($urandom_range(0, 15)); vbl = 5'($urandom_range(0, 20));
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    int n;
    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; a = 0; b = 0; approx_en = 0; hbl = 0; vbl = 0;
    in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; approx_en4 = 0; hbl4 = 0; vbl4 = 0;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset p", p, 0);

    check("model exact", golden(8'd255, 8'd255, 1'b0, 0, 0), 65025);
    check("model hbl2", golden(8'd255, 8'd255, 1'b1, 2, 0), 64260);
    check("model vbl8", golden(8'd255, 8'd255, 1'b1, 0, 8), 63232);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    start_op(8'd255, 8'd255, 1'b0, 4'd0, 5'd0);  wait_result(16'd65025, "exact max");  consume();
    start_op(8'd0,   8'd200, 1'b0, 4'd0, 5'd0);  wait_result(16'd0,     "zero a");     consume();
    start_op(8'd255, 8'd255, 1'b1, 4'd2, 5'd0);  wait_result(16'd64260, "hbl2");       consume();
    start_op(8'd255, 8'd255, 1'b1, 4'd0, 5'd8);  wait_result(16'd63232, "vbl8");       consume();
    start_op(8'd255, 8'd255, 1'b1, 4'd8, 5'd0);  wait_result(16'd0,     "hbl8");       consume();
    start_op(8'd255, 8'd255, 1'b1, 4'd0, 5'd15); wait_result(16'd0,     "vbl15");      consume();
    start_op(8'd200, 8'd99,  1'b1, 4'd0, 5'd0);  wait_result(16'd19800, "approx zero levels");

    held = p;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp p stable", p, held);
      check("bp out_valid", out_valid, 1);
      check("bp in_ready", in_ready, 0);
    end
    consume();

    start_op(8'd7, 8'd9, 1'b0, 4'd0, 5'd0); wait_result(16'd63, "pre b2b");
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 8'd3; b = 8'd5; approx_en = 1'b0;
    @(posedge clk); #1;
    check("b2b out_valid drop", out_valid, 0);
    check("b2b busy", busy, 1);
    in_valid = 1'b0; out_ready = 1'b0;
    wait_result(16'd15, "b2b");
    consume();

    start_op(8'd255, 8'd255, 1'b0, 4'd0, 5'd0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset in_ready", in_ready, 1);
    check("midreset busy", busy, 0);
    check("midreset p", p, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_op(8'd10, 8'd12, 1'b0, 4'd0, 5'd0); wait_result(16'd120, "after reset"); consume();

    @(negedge clk);
    in_valid4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    n = 0;
    while (!out_valid4 && n < 20) begin @(posedge clk); #1; n++; end
    check("w4 latency", n, 5);
    check("w4 p", p4, 225);

    stream(1'b0, 3000);
    stream(1'b1, 3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
